// File: rtl/ui_pkg.sv
// Shared types and defaults for the operand-entry sequencer.
package ui_pkg;

    localparam int unsigned NUM_FIELDS_DEF = 3;
    localparam int unsigned FIELD_W_DEF    = 9;
    localparam int unsigned DEB_CYC_DEF    = 4;
    localparam int unsigned IDX_W          = 3;

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_HOLD    = 2'd1,
        S_WAIT_GO = 2'd2,
        S_RUN     = 2'd3
    } state_t;

endpackage

// File: rtl/ui_debounce.sv
// Single-bit key debouncer: the output level follows the raw input only after
// the raw input has held its new value for DEB_CYC consecutive cycles.
module ui_debounce #(
    parameter int unsigned DEB_CYC = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level
);

    localparam int unsigned CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (i_raw != r_level) begin
            // The DEB_CYC-th consecutive differing sample commits the change.
            if (r_cnt == CNT_W'(DEB_CYC - 1)) begin
                r_level <= i_raw;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/ui_sequencer.sv
// Collects NUM_FIELDS operand fields from switches via debounced set keys,
// then launches the downstream engine on go and waits for done.
import ui_pkg::*;

module ui_sequencer #(
    parameter int unsigned NUM_FIELDS = NUM_FIELDS_DEF,
    parameter int unsigned FIELD_W    = FIELD_W_DEF,
    parameter int unsigned DEB_CYC    = DEB_CYC_DEF
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_FIELDS-1:0]         set_key,
    input  logic                          go,
    input  logic                          cancel,
    input  logic [FIELD_W-1:0]            data_in,
    input  logic                          done,
    output logic                          start,
    output logic [NUM_FIELDS*FIELD_W-1:0] fields,
    output logic [IDX_W-1:0]              cur_field,
    output logic [NUM_FIELDS-1:0]         capture,
    output logic                          ready_go
);

    localparam int unsigned NK = NUM_FIELDS + 2;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [IDX_W-1:0]                r_cur;
    logic [IDX_W-1:0]                w_cur_nxt;
    logic [NUM_FIELDS*FIELD_W-1:0]   r_fields;
    logic [NUM_FIELDS-1:0]           r_capture;
    logic [NUM_FIELDS-1:0]           w_cap_nxt;

    logic [NK-1:0]                   w_raw;
    logic [NK-1:0]                   w_deb;
    logic [NK-1:0]                   r_deb_d;
    logic [NK-1:0]                   w_rise;
    logic [NUM_FIELDS-1:0]           w_set_fall;
    logic                            w_key_rise;
    logic                            w_key_fall;
    logic                            w_go_rise;
    logic                            w_cancel_rise;

    // Key order in the debouncer bank: set keys, then go, then cancel.
    assign w_raw = {cancel, go, set_key};

    for (genvar g = 0; g < NK; g++) begin : g_deb
        ui_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .i_clk   (clk),
            .i_rst_n (resetn),
            .i_raw   (w_raw[g]),
            .o_level (w_deb[g])
        );
    end

    assign w_rise        = w_deb & ~r_deb_d;
    assign w_set_fall    = ~w_deb[NUM_FIELDS-1:0] & r_deb_d[NUM_FIELDS-1:0];
    assign w_go_rise     = w_rise[NUM_FIELDS];
    assign w_cancel_rise = w_rise[NUM_FIELDS+1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_WAIT;
            r_cur     <= '0;
            r_fields  <= '0;
            r_capture <= '0;
            r_deb_d   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur     <= w_cur_nxt;
            r_capture <= w_cap_nxt;
            r_deb_d   <= w_deb;
            for (int unsigned k = 0; k < NUM_FIELDS; k++) begin
                if (w_cap_nxt[k])
                    r_fields[k*FIELD_W +: FIELD_W] <= data_in;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_cap_nxt   = '0;
        w_key_rise  = 1'b0;
        w_key_fall  = 1'b0;
        for (int unsigned k = 0; k < NUM_FIELDS; k++) begin
            if (r_cur == IDX_W'(k)) begin
                w_key_rise = w_rise[k];
                w_key_fall = w_set_fall[k];
            end
        end
        case (r_state)
            S_WAIT: begin
                if (w_key_rise)
                    w_state_nxt = S_HOLD;
                else if (w_cancel_rise && (r_cur != '0))
                    w_cur_nxt = r_cur - 1'b1;
            end
            S_HOLD: begin
                if (w_key_fall) begin
                    for (int unsigned k = 0; k < NUM_FIELDS; k++)
                        w_cap_nxt[k] = (r_cur == IDX_W'(k));
                    if (r_cur == IDX_W'(NUM_FIELDS - 1)) begin
                        w_state_nxt = S_WAIT_GO;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cur_nxt   = r_cur + 1'b1;
                    end
                end
            end
            S_WAIT_GO: begin
                if (w_go_rise) begin
                    w_state_nxt = S_RUN;
                end else if (w_cancel_rise) begin
                    w_state_nxt = S_WAIT;
                    w_cur_nxt   = IDX_W'(NUM_FIELDS - 1);
                end
            end
            S_RUN: begin
                if (done) begin
                    w_state_nxt = S_WAIT;
                    w_cur_nxt   = '0;
                end
            end
            default: w_state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        start    = (r_state == S_RUN);
        ready_go = (r_state == S_WAIT_GO);
    end

    assign capture   = r_capture;
    assign fields    = r_fields;
    assign cur_field = r_cur;

endmodule

// File: tb/tb_ui_sequencer.sv
// Directed bench for ui_sequencer with a capture scoreboard.
module tb_ui_sequencer;

    localparam int NF = 3;
    localparam int FW = 9;
    localparam int DC = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NF-1:0]     set_key;
    logic              go;
    logic              cancel;
    logic [FW-1:0]     data_in;
    logic              done;
    logic              start;
    logic [NF*FW-1:0]  fields;
    logic [2:0]        cur_field;
    logic [NF-1:0]     capture;
    logic              ready_go;

    typedef struct {
        int          idx;
        logic [8:0]  val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ui_sequencer #(.NUM_FIELDS(NF), .FIELD_W(FW), .DEB_CYC(DC)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .set_key   (set_key),
        .go        (go),
        .cancel    (cancel),
        .data_in   (data_in),
        .done      (done),
        .start     (start),
        .fields    (fields),
        .cur_field (cur_field),
        .capture   (capture),
        .ready_go  (ready_go)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_field(input int k, input logic [8:0] v);
        exp_t e;
        data_in    = v;
        set_key[k] = 1'b1;
        cycles(7);
        e.idx = k;
        e.val = v;
        sb.push_back(e);
        set_key[k] = 1'b0;
        cycles(7);
    endtask

    task automatic press_cancel();
        cancel = 1'b1;
        cycles(7);
        cancel = 1'b0;
        cycles(7);
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1 && capture !== '0) begin
            exp_t e;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_capture: observed=%0h expected=0", capture);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("capture_onehot", 32'(capture), 32'(1) << e.idx);
                check("capture_value", 32'(fields[e.idx*FW +: FW]), 32'(e.val));
            end
        end
    end

    initial begin
        int waited;
        resetn  = 1'b0;
        set_key = '0;
        go      = 1'b0;
        cancel  = 1'b0;
        data_in = '0;
        done    = 1'b0;
        #12;
        check("rst_start", 32'(start), 0);
        check("rst_ready_go", 32'(ready_go), 0);
        check("rst_cur", 32'(cur_field), 0);
        check("rst_fields", 32'(fields), 0);
        check("rst_capture", 32'(capture), 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cycles(2);

        // 3-cycle glitch must not register
        set_key[0] = 1'b1;
        cycles(3);
        set_key[0] = 1'b0;
        cycles(8);
        check("glitch_cur", 32'(cur_field), 0);

        // key of a non-current field is ignored
        data_in    = 9'd99;
        set_key[2] = 1'b1;
        cycles(7);
        set_key[2] = 1'b0;
        cycles(7);
        check("other_key_cur", 32'(cur_field), 0);
        check("other_key_fields", 32'(fields), 0);

        press_field(0, 9'd10);
        check("cap0_cur", 32'(cur_field), 1);
        press_cancel();
        check("cancel_cur", 32'(cur_field), 0);
        press_field(0, 9'd5);
        check("recap_field0", 32'(fields[0 +: FW]), 5);
        check("recap_cur", 32'(cur_field), 1);
        press_cancel();
        check("cancel2_cur", 32'(cur_field), 0);
        press_cancel();
        check("cancel_at0_cur", 32'(cur_field), 0);

        // simultaneous set_key[0] and cancel: set wins, capture proves S_HOLD
        data_in    = 9'd10;
        set_key[0] = 1'b1;
        cancel     = 1'b1;
        cycles(7);
        sb.push_back('{0, 9'd10});
        set_key[0] = 1'b0;
        cancel     = 1'b0;
        cycles(7);
        check("simul_cur", 32'(cur_field), 1);

        press_field(1, 9'd20);
        check("ready_before_last", 32'(ready_go), 0);
        press_field(2, 9'd30);
        check("fields_all", 32'(fields), {5'd0, 9'd30, 9'd20, 9'd10});
        check("ready_go", 32'(ready_go), 1);
        check("last_cur", 32'(cur_field), 2);

        press_cancel();
        check("waitgo_cancel_ready", 32'(ready_go), 0);
        check("waitgo_cancel_cur", 32'(cur_field), 2);
        press_field(2, 9'd30);
        check("reentered_ready", 32'(ready_go), 1);

        done = 1'b1;
        cycles(1);
        done = 1'b0;
        cycles(1);
        check("done_ignored_ready", 32'(ready_go), 1);
        check("done_ignored_start", 32'(start), 0);

        go = 1'b1;
        waited = 0;
        while (start !== 1'b1 && waited < 20) begin
            cycles(1);
            waited++;
        end
        check("start_asserted", 32'(start), 1);
        go = 1'b0;
        data_in    = 9'd77;
        set_key[0] = 1'b1;
        cycles(7);
        set_key[0] = 1'b0;
        cycles(7);
        check("run_start_held", 32'(start), 1);
        check("run_fields_frozen", 32'(fields), {5'd0, 9'd30, 9'd20, 9'd10});
        done = 1'b1;
        check("start_before_done", 32'(start), 1);
        cycles(1);
        done = 1'b0;
        check("done_start", 32'(start), 0);
        check("done_cur", 32'(cur_field), 0);
        check("done_fields", 32'(fields), {5'd0, 9'd30, 9'd20, 9'd10});

        press_field(0, 9'd1);
        press_field(1, 9'd2);
        press_field(2, 9'd3);
        check("second_fields", 32'(fields), {5'd0, 9'd3, 9'd2, 9'd1});
        go = 1'b1;
        waited = 0;
        while (start !== 1'b1 && waited < 20) begin
            cycles(1);
            waited++;
        end
        check("second_start", 32'(start), 1);
        go = 1'b0;
        cycles(2);
        #2;
        resetn = 1'b0;
        #1;
        check("midrun_rst_start", 32'(start), 0);
        check("midrun_rst_fields", 32'(fields), 0);
        cycles(2);
        resetn = 1'b1;
        cycles(3);
        check("post_rst_cur", 32'(cur_field), 0);
        check("post_rst_fields", 32'(fields), 0);
        check("post_rst_start", 32'(start), 0);
        check("sb_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
